// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the fetch PC of the pipelined MIPS core and drives the
// instruction memory address directly.
//
// State table:
//   state  | meaning
//   RUN    | normal fetch; pc_f advances by +4 or to a branch target
//   SQUASH | post-ERET bubbles; pc_f holds at EPC, fetch slots invalid
//
// Ports:
//   clk, reset         rising-edge clock, async active-high reset
//   stall              D-stage hazard stall; PC, state and bubble count hold
//   br_take/br_target  D-stage taken branch/jump and its target
//   exc_req            CP0 accepted exception/interrupt; jump to HANDLER
//   eret_req/epc       ERET in D and its return address
//   pc_f               current fetch address
//   fetch_valid        word at pc_f is a real instruction (else inject nop)
//   adel_f             fetch address error at pc_f
//   squash_busy        sequencer is in SQUASH
//   fetch_cnt          count of valid, unstalled fetches (wraps)
module fetch_sequencer #(
    parameter logic [31:0] PC_RESET     = 32'h0000_3000,
    parameter logic [31:0] HANDLER      = 32'h0000_4180,
    parameter logic [31:0] IM_BASE      = 32'h0000_3000,
    parameter logic [31:0] IM_TOP       = 32'h0000_6FFC,
    parameter int unsigned ERET_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_take,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc_f,
    output logic        fetch_valid,
    output logic        adel_f,
    output logic        squash_busy,
    output logic [31:0] fetch_cnt
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    localparam logic [1:0] BUB_INIT = 2'(ERET_BUBBLES);

    state_t     state;
    logic [1:0] bub_cnt;

    assign adel_f      = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) || (pc_f > IM_TOP);
    // The slot fetched alongside an ERET in D is wrong-path, stalled or not.
    assign fetch_valid = !adel_f && (state == RUN) && !eret_req;
    assign squash_busy = (state == SQUASH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f      <= PC_RESET;
            state     <= RUN;
            bub_cnt   <= 2'd0;
            fetch_cnt <= 32'd0;
        end else begin
            if (fetch_valid && !stall && !exc_req)
                fetch_cnt <= fetch_cnt + 32'd1;

            if (exc_req) begin
                pc_f    <= HANDLER;
                state   <= RUN;
                bub_cnt <= 2'd0;
            end else if (eret_req && !stall) begin
                pc_f <= epc;
                if (ERET_BUBBLES == 0) begin
                    state <= RUN;
                end else begin
                    state   <= SQUASH;
                    bub_cnt <= BUB_INIT;
                end
            end else if (stall) begin
                // hold everything; a stalled ERET is re-presented by D
            end else if (state == SQUASH) begin
                bub_cnt <= bub_cnt - 2'd1;
                if (bub_cnt == 2'd1)
                    state <= RUN;
            end else if (br_take) begin
                pc_f <= br_target;
            end else begin
                pc_f <= pc_f + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: table of {inputs, expected outputs} vectors
// applied one per cycle; expected records go through a scoreboard queue and are
// compared against the outputs sampled 1 ns after inputs are driven (mid-cycle).
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, br_take, exc_req, eret_req;
    logic [31:0] br_target, epc;
    logic [31:0] pc_f, fetch_cnt;
    logic        fetch_valid, adel_f, squash_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        stall;
        logic        br_take;
        logic [31:0] br_target;
        logic        exc_req;
        logic        eret_req;
        logic [31:0] epc;
        logic [31:0] pc;
        logic        valid;
        logic        adel;
        logic        busy;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .br_take(br_take),
        .br_target(br_target), .exc_req(exc_req), .eret_req(eret_req),
        .epc(epc), .pc_f(pc_f), .fetch_valid(fetch_valid), .adel_f(adel_f),
        .squash_busy(squash_busy), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic bt, input logic [31:0] tgt,
                                input logic ex, input logic er, input logic [31:0] ep,
                                input logic [31:0] pc, input logic v, input logic a,
                                input logic b, input logic [31:0] cnt);
        vec_t r;
        r.stall = st; r.br_take = bt; r.br_target = tgt; r.exc_req = ex;
        r.eret_req = er; r.epc = ep; r.pc = pc; r.valid = v; r.adel = a;
        r.busy = b; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag);
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = sb.pop_front();
        chk32({tag, ".pc_f"},        pc_f,                 e.pc);
        chk32({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e.valid});
        chk32({tag, ".adel_f"},      {31'd0, adel_f},      {31'd0, e.adel});
        chk32({tag, ".squash_busy"}, {31'd0, squash_busy}, {31'd0, e.busy});
        chk32({tag, ".fetch_cnt"},   fetch_cnt,            e.cnt);
    endtask

    // Called at a negedge: drive inputs, queue expectation, sample mid-cycle.
    task automatic apply(input vec_t v, input string tag);
        stall     = v.stall;
        br_take   = v.br_take;
        br_target = v.br_target;
        exc_req   = v.exc_req;
        eret_req  = v.eret_req;
        epc       = v.epc;
        sb.push_back(v);
        #1;
        check_out(tag);
    endtask

    initial begin
        reset = 1'b1;
        stall = 0; br_take = 0; br_target = 0; exc_req = 0; eret_req = 0; epc = 0;

        //        st bt target        ex er epc           pc            v  a  b  cnt
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3004, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3008, 1, 0, 0, 2));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_300C, 1, 0, 0, 3));
        tbl.push_back(mk(0, 0, 32'h0,        0, 1, 32'h3204,     32'h0000_3010, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3204, 0, 0, 1, 4));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3204, 1, 0, 0, 4));
        tbl.push_back(mk(1, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_3208, 1, 0, 0, 5));
        tbl.push_back(mk(0, 1, 32'h3100,     0, 0, 32'h0,        32'h0000_3208, 1, 0, 0, 5));
        tbl.push_back(mk(1, 0, 32'h0,        0, 1, 32'h3300,     32'h0000_3100, 0, 0, 0, 6));
        tbl.push_back(mk(0, 0, 32'h0,        0, 1, 32'h3300,     32'h0000_3100, 0, 0, 0, 6));
        tbl.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        32'h0000_3300, 0, 0, 1, 6));
        tbl.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        32'h0000_4180, 1, 0, 0, 6));
        tbl.push_back(mk(0, 1, 32'h3102,     0, 0, 32'h0,        32'h0000_4180, 1, 0, 0, 6));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3102, 0, 1, 0, 7));
        tbl.push_back(mk(0, 1, 32'h7000,     0, 0, 32'h0,        32'h0000_3106, 0, 1, 0, 7));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_7000, 0, 1, 0, 7));
        tbl.push_back(mk(0, 0, 32'h0,        1, 0, 32'h0,        32'h0000_7004, 0, 1, 0, 7));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_4180, 1, 0, 0, 7));
        tbl.push_back(mk(0, 1, 32'h6FFC,     0, 0, 32'h0,        32'h0000_4184, 1, 0, 0, 8));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_6FFC, 1, 0, 0, 9));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_7000, 0, 1, 0, 10));
        tbl.push_back(mk(0, 0, 32'h0,        1, 1, 32'h3204,     32'h0000_7004, 0, 1, 0, 10));
        tbl.push_back(mk(0, 1, 32'h2FFC,     0, 0, 32'h0,        32'h0000_4180, 1, 0, 0, 10));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_2FFC, 0, 1, 0, 11));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_3000, 1, 0, 0, 11));
        tbl.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,       32'h0000_3004, 1, 0, 0, 12));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'hFFFF_FFFC, 0, 1, 0, 13));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        32'h0000_0000, 0, 1, 0, 13));

        // reset state while reset is held
        #2;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0000_3000, 1, 0, 0, 0));
        check_out("reset");

        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Stall during SQUASH holds the bubble count.
        apply(mk(0, 0, 0, 0, 1, 32'h3204, 32'h0000_0004, 0, 1, 0, 13), "sq_eret");
        @(negedge clk);
        apply(mk(1, 0, 0, 0, 0, 0, 32'h0000_3204, 0, 0, 1, 13), "sq_stall");
        @(negedge clk);
        apply(mk(0, 0, 0, 0, 0, 0, 32'h0000_3204, 0, 0, 1, 13), "sq_held");
        @(negedge clk);
        apply(mk(0, 0, 0, 0, 0, 0, 32'h0000_3204, 1, 0, 0, 13), "sq_done");
        @(negedge clk);

        // Async reset mid-SQUASH, asserted away from any clock edge.
        apply(mk(0, 0, 0, 0, 1, 32'h3204, 32'h0000_3208, 0, 0, 0, 14), "rst_eret");
        @(negedge clk);
        apply(mk(1, 0, 0, 0, 0, 0, 32'h0000_3204, 0, 0, 1, 14), "rst_sq");
        @(posedge clk);
        #2;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0000_3204, 0, 0, 1, 14));
        check_out("pre_rst");
        stall = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0000_3000, 1, 0, 0, 0));
        check_out("async_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the fetch PC for the pipelined MIPS core and sequences the instruction memory.
- Picks the next fetch address each cycle from: reset vector, sequential PC+4, branch/jump target, exception handler entry, or ERET return (EPC).
- Squashes fetch slots made invalid by ERET and flags fetch address errors (AdEL).
- Sits between the D-stage branch unit / CP0 and the instruction memory. Its PC output drives the memory address directly.

Parameters:
- PC_RESET, 32'h0000_3000, fetch address after reset.
- HANDLER, 32'h0000_4180, exception/interrupt entry address.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_TOP, 32'h0000_6FFC, highest legal fetch address (inclusive).
- ERET_BUBBLES, 1, extra squashed cycles after an ERET redirect (range 0..3).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall from the D stage; hold the PC.
- br_take  in  1  D-stage branch/jump taken.
- br_target  in  32  branch/jump target.
- exc_req  in  1  CP0 exception/interrupt accepted this cycle.
- eret_req  in  1  ERET present in the D stage.
- epc  in  32  return address from CP0.
- pc_f  out  32  current fetch address to the instruction memory.
- fetch_valid  out  1  the word at pc_f is a real instruction; 0 means F stage must inject a nop.
- adel_f  out  1  fetch address error at pc_f.
- squash_busy  out  1  sequencer is in the SQUASH state.
- fetch_cnt  out  32  count of valid, unstalled fetches.

Behaviour:
- Reset (async): pc_f=PC_RESET, state=RUN, bubble counter=0, fetch_cnt=0.
  - Resulting outputs: fetch_valid=1, adel_f=0, squash_busy=0.
- States: RUN, SQUASH. squash_busy = (state==SQUASH).
- Next-PC priority, evaluated every rising edge, highest first:
  1. exc_req: pc_f<=HANDLER, state<=RUN, bubble counter<=0. Overrides stall and any SQUASH in progress.
  2. eret_req && !stall: pc_f<=epc.
     - ERET_BUBBLES=0: state stays RUN.
     - Otherwise: state<=SQUASH, counter<=ERET_BUBBLES.
  3. stall: pc_f holds; state and counter hold.
  4. state==SQUASH: pc_f holds. Counter decrements; when it reaches 0 (counter==1 before the edge), state<=RUN.
  5. br_take: pc_f<=br_target.
  6. Otherwise: pc_f<=pc_f+4, modulo 2^32 (wraps silently; the wrapped address then raises adel_f).
- eret_req while stall=1 is ignored; the ERET is held in D and re-presented.
- br_take is ignored in SQUASH state and while stall=1.
- adel_f (combinational from pc_f) = 1 when any of:
  - pc_f[1:0]!=0
  - pc_f<IM_BASE
  - pc_f>IM_TOP
- fetch_valid (combinational) = !adel_f && state==RUN && !eret_req.
  - The slot fetched in the same cycle as an accepted ERET is always squashed, stalled or not.
- fetch_cnt increments on an edge where fetch_valid=1, stall=0 and exc_req=0. 32-bit, wraps.
- Latency: a redirect on edge N makes the new pc_f visible right after edge N, so the new address is fetched in cycle N+1.
- Simultaneous exc_req and eret_req: the exception wins; pc_f=HANDLER.
- Reset asserted mid-SQUASH: immediate return to the reset values.

Test Plan:
- Release reset, no other inputs, 4 cycles -> pc_f = 3000, 3004, 3008, 300C; fetch_valid=1 throughout; fetch_cnt=4.
- At pc_f=3008, br_take=1 with br_target=3100 -> next pc_f=3100. Repeat with stall=1 in the same cycle -> pc_f holds 3008 and the branch is ignored.
- At pc_f=3010, eret_req=1 with epc=3204 (ERET_BUBBLES=1):
  - fetch_valid=0 that cycle.
  - Next cycle: pc_f=3204, squash_busy=1, fetch_valid=0.
  - Following cycle: pc_f=3204, fetch_valid=1.
- During the SQUASH cycle, assert exc_req -> next pc_f=4180, state RUN, fetch_valid=1. Separately, exc_req with stall=1 -> pc_f=4180.
- br_target=3102 -> adel_f=1, fetch_valid=0. br_target=7000 -> adel_f=1. Then exc_req -> pc_f=4180, adel_f=0.
- Assert reset asynchronously mid-cycle while in SQUASH with pc_f=3204 -> pc_f=3000, squash_busy=0, fetch_cnt=0 without waiting for a clock edge.
